// File: rtl/stats_tracker_log.sv
// Circular stats log with a META query (ring pointers) and a DATA query that
// streams stored entries packed DATA_W/STATS_W per line, first entry in the MSBs.
module stats_tracker_log #(
    parameter int TRACKER_ADDR_W = 8,
    parameter int STATS_W        = 128,
    parameter int DATA_W         = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      log_val,
    input  logic [STATS_W-1:0]        log_data,
    input  logic                      req_val,
    output logic                      req_rdy,
    input  logic                      req_type,
    input  logic [TRACKER_ADDR_W-1:0] req_start_addr,
    input  logic [TRACKER_ADDR_W-1:0] req_end_addr,
    output logic                      resp_val,
    input  logic                      resp_rdy,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_last
);

    localparam int W     = TRACKER_ADDR_W;
    localparam int EPL   = DATA_W / STATS_W;
    localparam int SHIFT = $clog2(EPL);
    localparam int IDX_W = SHIFT + 1;
    localparam int DEPTH = 1 << W;

    typedef enum logic [1:0] {IDLE, META_OUT, RD_ISSUE, RD_OUT} state_t;

    state_t             state;
    logic [W-1:0]       start_addr;
    logic [W-1:0]       end_addr;
    logic [W-1:0]       cursor;
    logic [W-1:0]       limit;
    logic [W:0]         lines_left;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   cap_idx;
    logic               rd_pend;
    logic [DATA_W-1:0]  line_buf;
    logic [STATS_W-1:0] mem [DEPTH];
    logic [STATS_W-1:0] mem_q;
    logic               rd_en;
    logic [W-1:0]       req_n;
    logic [W:0]         req_lines;

    assign resp_data = line_buf;

    always_comb begin
        rd_en     = (state == RD_ISSUE) && (issue_idx != IDX_W'(EPL)) && (cursor != limit);
        req_n     = req_end_addr - req_start_addr;
        req_lines = ({1'b0, req_n} + (W+1)'(EPL - 1)) >> SHIFT;
        if (req_lines == '0)
            req_lines = (W+1)'(1);
    end

    // Storage: one write port, one registered read port (read-before-write).
    always_ff @(posedge clk) begin
        if (log_val)
            mem[end_addr] <= log_data;
        if (rd_en)
            mem_q <= mem[cursor];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_addr <= '0;
            end_addr   <= '0;
            cursor     <= '0;
            limit      <= '0;
            lines_left <= '0;
            issue_idx  <= '0;
            cap_idx    <= '0;
            rd_pend    <= 1'b0;
            line_buf   <= '0;
            req_rdy    <= 1'b0;
            resp_val   <= 1'b0;
            resp_last  <= 1'b0;
        end else begin
            // Logging never stalls; a full ring drops its oldest entry.
            if (log_val) begin
                end_addr <= end_addr + W'(1);
                if (end_addr + W'(1) == start_addr)
                    start_addr <= start_addr + W'(1);
            end

            case (state)
                IDLE: begin
                    req_rdy <= 1'b1;
                    if (req_val && req_rdy) begin
                        req_rdy <= 1'b0;
                        if (!req_type) begin
                            line_buf  <= {start_addr, end_addr, {(DATA_W-2*W){1'b0}}};
                            resp_val  <= 1'b1;
                            resp_last <= 1'b1;
                            state     <= META_OUT;
                        end else begin
                            cursor     <= req_start_addr;
                            limit      <= req_end_addr;
                            lines_left <= req_lines;
                            line_buf   <= '0;
                            issue_idx  <= '0;
                            cap_idx    <= '0;
                            rd_pend    <= 1'b0;
                            state      <= RD_ISSUE;
                        end
                    end
                end

                META_OUT: begin
                    if (resp_rdy) begin
                        resp_val  <= 1'b0;
                        resp_last <= 1'b0;
                        req_rdy   <= 1'b1;
                        state     <= IDLE;
                    end
                end

                RD_ISSUE: begin
                    // Data from the previous cycle's read lands in the next free slot.
                    if (rd_pend) begin
                        for (int k = 0; k < EPL; k++) begin
                            if (cap_idx == IDX_W'(k))
                                line_buf[DATA_W-1-k*STATS_W -: STATS_W] <= mem_q;
                        end
                        cap_idx <= cap_idx + IDX_W'(1);
                    end
                    if (rd_en) begin
                        cursor    <= cursor + W'(1);
                        issue_idx <= issue_idx + IDX_W'(1);
                        rd_pend   <= 1'b1;
                    end else begin
                        rd_pend   <= 1'b0;
                        resp_val  <= 1'b1;
                        resp_last <= (lines_left == (W+1)'(1));
                        state     <= RD_OUT;
                    end
                end

                RD_OUT: begin
                    if (resp_rdy) begin
                        resp_val   <= 1'b0;
                        resp_last  <= 1'b0;
                        lines_left <= lines_left - (W+1)'(1);
                        if (lines_left == (W+1)'(1)) begin
                            req_rdy <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            line_buf  <= '0;
                            issue_idx <= '0;
                            cap_idx   <= '0;
                            rd_pend   <= 1'b0;
                            state     <= RD_ISSUE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stats_tracker_log.sv
// Directed bench for stats_tracker_log (W=3, EPL=4) with a ring model and
// a queue of expected response beats.
module tb_stats_tracker_log;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         log_val;
    logic [127:0] log_data;
    logic         req_val;
    logic         req_rdy;
    logic         req_type;
    logic [2:0]   req_start_addr;
    logic [2:0]   req_end_addr;
    logic         resp_val;
    logic         resp_rdy;
    logic [511:0] resp_data;
    logic         resp_last;

    stats_tracker_log #(.TRACKER_ADDR_W(3), .STATS_W(128), .DATA_W(512)) dut (
        .clk(clk), .rst_n(rst_n),
        .log_val(log_val), .log_data(log_data),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_start_addr(req_start_addr), .req_end_addr(req_end_addr),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_data(resp_data), .resp_last(resp_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } beat_t;

    beat_t        sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] mmem [8];
    logic [2:0]   m_start = 3'd0;
    logic [2:0]   m_end   = 3'd0;

    function automatic logic [127:0] ent(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'(i * 7 + 1), 32'hFACE_0000 | 32'(i), ~32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_log(input logic [127:0] v);
        log_val  = 1'b1;
        log_data = v;
        mmem[m_end] = v;
        if (m_end + 3'd1 == m_start)
            m_start = m_start + 3'd1;
        m_end = m_end + 3'd1;
        @(negedge clk);
        log_val = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        log_val  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_start = 3'd0;
        m_end   = 3'd0;
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (req_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy_wait", {511'd0, req_rdy}, 512'd1);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_val !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_val_wait", {511'd0, resp_val}, 512'd1);
    endtask

    task automatic push_expected(input logic typ, input logic [2:0] s, input logic [2:0] e);
        beat_t b;
        int    n;
        int    lines;
        if (!typ) begin
            b.data = {m_start, m_end, 506'd0};
            b.last = 1'b1;
            sbq.push_back(b);
        end else begin
            n     = int'(3'(e - s));
            lines = (n == 0) ? 1 : (n + 3) / 4;
            for (int l = 0; l < lines; l++) begin
                b.data = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * l + j < n)
                        b.data[511 - j * 128 -: 128] = mmem[3'(int'(s) + 4 * l + j)];
                end
                b.last = (l == lines - 1);
                sbq.push_back(b);
            end
        end
    endtask

    task automatic do_req(input logic typ, input logic [2:0] s, input logic [2:0] e);
        wait_rdy();
        push_expected(typ, s, e);
        req_val        = 1'b1;
        req_type       = typ;
        req_start_addr = s;
        req_end_addr   = e;
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic collect(input string tag, input int nbeats, input int stall);
        beat_t        b;
        logic [511:0] snap;
        for (int k = 0; k < nbeats; k++) begin
            wait_resp();
            if (k == 0 && stall > 0) begin
                snap = resp_data;
                for (int c = 0; c < stall; c++) begin
                    @(negedge clk);
                    chk({tag, "_stall_val"}, {511'd0, resp_val}, 512'd1);
                    chk({tag, "_stall_data"}, resp_data, snap);
                    chk({tag, "_stall_req_rdy"}, {511'd0, req_rdy}, 512'd0);
                end
            end
            if (sbq.size() == 0) begin
                chk({tag, "_sb_underflow"}, 512'(sbq.size()), 512'd1);
            end else begin
                b = sbq.pop_front();
                chk({tag, "_data"}, resp_data, b.data);
                chk({tag, "_last"}, {511'd0, resp_last}, {511'd0, b.last});
            end
            resp_rdy = 1'b1;
            @(negedge clk);
            resp_rdy = 1'b0;
        end
        wait_rdy();
        chk({tag, "_sb_empty"}, 512'(sbq.size()), 512'd0);
        chk({tag, "_idle_resp_val"}, {511'd0, resp_val}, 512'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        log_val        = 1'b0;
        log_data       = '0;
        req_val        = 1'b0;
        req_type       = 1'b0;
        req_start_addr = '0;
        req_end_addr   = '0;
        resp_rdy       = 1'b0;

        // Outputs while reset is held
        #2;
        chk("rst_req_rdy", {511'd0, req_rdy}, 512'd0);
        chk("rst_resp_val", {511'd0, resp_val}, 512'd0);
        chk("rst_resp_last", {511'd0, resp_last}, 512'd0);
        chk("rst_resp_data", resp_data, 512'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_req_rdy", {511'd0, req_rdy}, 512'd1);

        // Five entries then META, plus a short DATA read
        for (int i = 0; i < 5; i++) do_log(ent(16'hA0 + i));
        do_req(1'b0, 3'd0, 3'd0);
        collect("meta_five", 1, 0);
        chk("meta_five_ptrs", {506'd0, m_start, m_end}, {506'd0, 3'd0, 3'd5});
        do_req(1'b1, 3'd1, 3'd3);
        collect("data_1_3", 1, 0);

        // Ten entries overflow the 7-entry ring
        do_reset();
        for (int i = 0; i < 10; i++) do_log(ent(i));
        do_req(1'b0, 3'd0, 3'd0);
        collect("meta_wrap", 1, 0);
        do_req(1'b1, 3'd3, 3'd2);
        collect("data_3_2", 2, 0);
        do_req(1'b1, 3'd4, 3'd4);
        collect("data_empty", 1, 0);
        do_req(1'b1, 3'd6, 3'd1);
        collect("data_6_1", 1, 0);

        // Back-pressure on the first line
        do_reset();
        for (int i = 0; i < 5; i++) do_log(ent(i));
        do_req(1'b1, 3'd0, 3'd5);
        collect("data_stall", 2, 4);

        // Reset mid-response while logging every cycle
        do_reset();
        log_val  = 1'b1;
        log_data = ent(99);
        wait_rdy();
        req_val        = 1'b1;
        req_type       = 1'b1;
        req_start_addr = 3'd0;
        req_end_addr   = 3'd5;
        @(negedge clk);
        req_val = 1'b0;
        wait_resp();
        rst_n = 1'b0;
        #1;
        chk("abort_resp_val", {511'd0, resp_val}, 512'd0);
        chk("abort_resp_last", {511'd0, resp_last}, 512'd0);
        chk("abort_resp_data", resp_data, 512'd0);
        chk("abort_req_rdy", {511'd0, req_rdy}, 512'd0);
        log_val = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_start = 3'd0;
        m_end   = 3'd0;
        sbq.delete();
        @(negedge clk);
        chk("abort_req_rdy_after", {511'd0, req_rdy}, 512'd1);
        resp_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_beats", {511'd0, resp_val}, 512'd0);
        end
        resp_rdy = 1'b0;
        do_req(1'b0, 3'd0, 3'd0);
        collect("meta_after_abort", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
